// File: rtl/iob_nco_multi.sv
// Multi-channel fractional NCO: shadowed period/duty registers reload at each period boundary.
// Optional per-channel start phase (cfg sel 5) is compiled in when IOB_NCO_MULTI_PHASE_EN is defined.
module iob_nco_multi #(
  parameter int N_CH   = 4,
  parameter int INT_W  = 16,
  parameter int FRAC_W = 16,
  parameter int DATA_W = 32,
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk_i,
  input  logic              cke_i,
  input  logic              arst_n_i,
  input  logic              cfg_valid_i,
  input  logic [2:0]        cfg_sel_i,
  input  logic [CH_W-1:0]   cfg_ch_i,
  input  logic [DATA_W-1:0] cfg_wdata_i,
  output logic              cfg_ready_o,
  output logic [N_CH-1:0]   clk_out_o,
  output logic [N_CH-1:0]   tick_o
);

  logic                ready_q, ready_d;
  logic [N_CH-1:0]     en_q, en_d, en_new_s;
  logic [N_CH-1:0]     clk_out_q, clk_out_d, tick_q, tick_d;
  logic [INT_W-1:0]    sh_int_q [N_CH], sh_int_d [N_CH];
  logic [INT_W-1:0]    sh_duty_q [N_CH], sh_duty_d [N_CH];
  logic [FRAC_W-1:0]   sh_frac_q [N_CH], sh_frac_d [N_CH];
  logic [INT_W-1:0]    act_int_q [N_CH], act_int_d [N_CH];
  logic [INT_W-1:0]    act_duty_q [N_CH], act_duty_d [N_CH];
  logic [FRAC_W-1:0]   act_frac_q [N_CH], act_frac_d [N_CH];
  logic [INT_W-1:0]    cnt_q [N_CH], cnt_d [N_CH];
  logic [FRAC_W-1:0]   acc_q [N_CH], acc_d [N_CH];
`ifdef IOB_NCO_MULTI_PHASE_EN
  logic [INT_W-1:0]    sh_phase_q [N_CH], sh_phase_d [N_CH];
`endif

  logic                wr_s, soft_s, ch_ok_s, live_s, end_s;
  logic [FRAC_W:0]     sum_s;
  logic [INT_W:0]      len_s;
  logic [INT_W-1:0]    start_s;
  logic                unused_wdata_s;

  assign unused_wdata_s = ^cfg_wdata_i;

  // Next-state logic: config decode, per-channel counters and output functions.
  always_comb begin
    wr_s    = cfg_valid_i && ready_q && cke_i;
    ch_ok_s = (32'(cfg_ch_i) < N_CH);
    soft_s  = wr_s && (cfg_sel_i == 3'd4) && cfg_wdata_i[0];
    if (wr_s && (cfg_sel_i == 3'd3)) begin
      en_new_s = cfg_wdata_i[N_CH-1:0];
    end else begin
      en_new_s = en_q;
    end

    ready_d    = ready_q;
    en_d       = en_q;
    clk_out_d  = clk_out_q;
    tick_d     = tick_q;
    sh_int_d   = sh_int_q;
    sh_duty_d  = sh_duty_q;
    sh_frac_d  = sh_frac_q;
    act_int_d  = act_int_q;
    act_duty_d = act_duty_q;
    act_frac_d = act_frac_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
`ifdef IOB_NCO_MULTI_PHASE_EN
    sh_phase_d = sh_phase_q;
`endif
    sum_s   = '0;
    len_s   = '0;
    live_s  = 1'b0;
    end_s   = 1'b0;
    start_s = '0;

    if (!cke_i) begin
      ready_d = ready_q;
    end else if (soft_s) begin
      ready_d   = 1'b0;
      en_d      = '0;
      clk_out_d = '0;
      tick_d    = '0;
      for (int i = 0; i < N_CH; i++) begin
        sh_int_d[i]   = '0;
        sh_duty_d[i]  = '0;
        sh_frac_d[i]  = '0;
        act_int_d[i]  = '0;
        act_duty_d[i] = '0;
        act_frac_d[i] = '0;
        cnt_d[i]      = '0;
        acc_d[i]      = '0;
`ifdef IOB_NCO_MULTI_PHASE_EN
        sh_phase_d[i] = '0;
`endif
      end
    end else begin
      ready_d = 1'b1;
      en_d    = en_new_s;
      for (int i = 0; i < N_CH; i++) begin
        // The fractional carry stretches this period by one cycle.
        sum_s  = {1'b0, acc_q[i]} + {1'b0, act_frac_q[i]};
        len_s  = {1'b0, act_int_q[i]} + {{INT_W{1'b0}}, sum_s[FRAC_W]};
        live_s = (act_int_q[i] >= INT_W'(2));
        end_s  = live_s && ({1'b0, cnt_q[i]} == (len_s - {{INT_W{1'b0}}, 1'b1}));
`ifdef IOB_NCO_MULTI_PHASE_EN
        if (sh_int_q[i] < INT_W'(2)) begin
          start_s = '0;
        end else if (sh_phase_q[i] > (sh_int_q[i] - INT_W'(1))) begin
          start_s = sh_int_q[i] - INT_W'(1);
        end else begin
          start_s = sh_phase_q[i];
        end
`else
        start_s = '0;
`endif
        clk_out_d[i] = en_q[i] && live_s && (cnt_q[i] < act_duty_q[i]);
        tick_d[i]    = en_q[i] && end_s;
        if (en_new_s[i] && !en_q[i]) begin
          cnt_d[i]      = start_s;
          acc_d[i]      = '0;
          act_int_d[i]  = sh_int_q[i];
          act_frac_d[i] = sh_frac_q[i];
          act_duty_d[i] = sh_duty_q[i];
        end else if (en_new_s[i] && end_s) begin
          cnt_d[i]      = '0;
          acc_d[i]      = sum_s[FRAC_W-1:0];
          act_int_d[i]  = sh_int_q[i];
          act_frac_d[i] = sh_frac_q[i];
          act_duty_d[i] = sh_duty_q[i];
        end else if (en_new_s[i] && en_q[i] && live_s) begin
          cnt_d[i] = cnt_q[i] + INT_W'(1);
        end else begin
          cnt_d[i] = cnt_q[i];
        end
      end
      // Shadow updates land after the reload above, so a same-edge write waits a period.
      if (wr_s && ch_ok_s) begin
        case (cfg_sel_i)
          3'd0: sh_int_d[cfg_ch_i]  = cfg_wdata_i[INT_W-1:0];
          3'd1: sh_frac_d[cfg_ch_i] = cfg_wdata_i[FRAC_W-1:0];
          3'd2: sh_duty_d[cfg_ch_i] = cfg_wdata_i[INT_W-1:0];
`ifdef IOB_NCO_MULTI_PHASE_EN
          3'd5: sh_phase_d[cfg_ch_i] = cfg_wdata_i[INT_W-1:0];
`endif
          default: ;
        endcase
      end else begin
        ready_d = 1'b1;
      end
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      ready_q   <= 1'b0;
      en_q      <= '0;
      clk_out_q <= '0;
      tick_q    <= '0;
      for (int i = 0; i < N_CH; i++) begin
        sh_int_q[i]   <= '0;
        sh_duty_q[i]  <= '0;
        sh_frac_q[i]  <= '0;
        act_int_q[i]  <= '0;
        act_duty_q[i] <= '0;
        act_frac_q[i] <= '0;
        cnt_q[i]      <= '0;
        acc_q[i]      <= '0;
`ifdef IOB_NCO_MULTI_PHASE_EN
        sh_phase_q[i] <= '0;
`endif
      end
    end else begin
      ready_q    <= ready_d;
      en_q       <= en_d;
      clk_out_q  <= clk_out_d;
      tick_q     <= tick_d;
      sh_int_q   <= sh_int_d;
      sh_duty_q  <= sh_duty_d;
      sh_frac_q  <= sh_frac_d;
      act_int_q  <= act_int_d;
      act_duty_q <= act_duty_d;
      act_frac_q <= act_frac_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
`ifdef IOB_NCO_MULTI_PHASE_EN
      sh_phase_q <= sh_phase_d;
`endif
    end
  end

  assign cfg_ready_o = ready_q;
  assign clk_out_o   = clk_out_q;
  assign tick_o      = tick_q;

endmodule

// File: tb/tb_iob_nco_multi.sv
// Self-checking bench for iob_nco_multi: directed scenarios plus random config traffic
// compared cycle by cycle against an integer-arithmetic model of the oscillator rules.
module tb_iob_nco_multi;
  localparam int N  = 4;
  localparam int IW = 16;
  localparam int FW = 16;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          cke, arst_n, valid;
  logic [2:0]    sel;
  logic [1:0]    ch;
  logic [DW-1:0] wdata;
  logic          ready;
  logic [N-1:0]  clk_out, tick;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  iob_nco_multi #(.N_CH(N), .INT_W(IW), .FRAC_W(FW), .DATA_W(DW)) dut (
    .clk_i(clk), .cke_i(cke), .arst_n_i(arst_n), .cfg_valid_i(valid),
    .cfg_sel_i(sel), .cfg_ch_i(ch), .cfg_wdata_i(wdata),
    .cfg_ready_o(ready), .clk_out_o(clk_out), .tick_o(tick)
  );

  // Reference model: position within the period and fractional residue as plain integers.
  int m_sh_int[N], m_sh_frac[N], m_sh_duty[N], m_sh_ph[N];
  int m_int[N], m_frac[N], m_duty[N], m_pos[N], m_acc[N];
  bit [N-1:0] m_en, m_clk, m_tick;
  bit m_ready;

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_sh_int[i] = 0; m_sh_frac[i] = 0; m_sh_duty[i] = 0; m_sh_ph[i] = 0;
      m_int[i] = 0; m_frac[i] = 0; m_duty[i] = 0; m_pos[i] = 0; m_acc[i] = 0;
    end
    m_en = '0; m_clk = '0; m_tick = '0; m_ready = 1'b0;
  endtask

  task automatic model_edge();
    bit wr;
    bit [N-1:0] new_en, nclk, ntick;
    if (!arst_n) begin model_clear(); return; end
    if (!cke) return;
    wr = valid && m_ready;
    if (wr && sel == 3'd4 && wdata[0]) begin model_clear(); return; end
    new_en = (wr && sel == 3'd3) ? wdata[N-1:0] : m_en;
    for (int i = 0; i < N; i++) begin
      int len, start;
      bit alive, last;
      alive = m_int[i] >= 2;
      len   = m_int[i] + (((m_acc[i] + m_frac[i]) >= (1 << FW)) ? 1 : 0);
      last  = alive && (m_pos[i] == len - 1);
      nclk[i]  = m_en[i] && alive && (m_pos[i] < m_duty[i]);
      ntick[i] = m_en[i] && last;
      start = 0;
`ifdef IOB_NCO_MULTI_PHASE_EN
      if (m_sh_int[i] >= 2) start = (m_sh_ph[i] < m_sh_int[i] - 1) ? m_sh_ph[i] : m_sh_int[i] - 1;
`endif
      if (new_en[i] && !m_en[i]) begin
        m_pos[i] = start; m_acc[i] = 0;
        m_int[i] = m_sh_int[i]; m_frac[i] = m_sh_frac[i]; m_duty[i] = m_sh_duty[i];
      end else if (new_en[i] && last) begin
        m_pos[i] = 0; m_acc[i] = (m_acc[i] + m_frac[i]) % (1 << FW);
        m_int[i] = m_sh_int[i]; m_frac[i] = m_sh_frac[i]; m_duty[i] = m_sh_duty[i];
      end else if (new_en[i] && m_en[i] && alive) begin
        m_pos[i] = m_pos[i] + 1;
      end
    end
    if (wr) begin
      case (sel)
        3'd0: m_sh_int[ch]  = int'(wdata[IW-1:0]);
        3'd1: m_sh_frac[ch] = int'(wdata[FW-1:0]);
        3'd2: m_sh_duty[ch] = int'(wdata[IW-1:0]);
`ifdef IOB_NCO_MULTI_PHASE_EN
        3'd5: m_sh_ph[ch]   = int'(wdata[IW-1:0]);
`endif
        default: ;
      endcase
    end
    m_en = new_en; m_clk = nclk; m_tick = ntick; m_ready = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic cfg_write(input logic [2:0] s, input logic [1:0] c, input logic [DW-1:0] d);
    valid = 1'b1; sel = s; ch = c; wdata = d;
    step();
    valid = 1'b0;
  endtask

  task automatic clean();
    cfg_write(3'd4, 2'd0, 32'd1);
    step();
  endtask

  task automatic test_reset();
    arst_n = 1'b0; cke = 1'b1; valid = 1'b0; sel = 3'd0; ch = 2'd0; wdata = 32'd0;
    model_clear();
    #12;
    checks++;
    if ({ready, clk_out, tick} !== 9'd0) begin
      errors++; $display("FAIL reset_state: ready=%b clk_out=%b tick=%b expected all 0", ready, clk_out, tick);
    end
    @(negedge clk); arst_n = 1'b1;
    step();
    checks++;
    if (ready !== 1'b1) begin
      errors++; $display("FAIL ready_after_reset: got %b expected 1", ready);
    end
  endtask

  task automatic test_basic();
    clean();
    cfg_write(3'd0, 2'd0, 32'd4); cfg_write(3'd1, 2'd0, 32'd0); cfg_write(3'd2, 2'd0, 32'd2);
    cfg_write(3'd3, 2'd0, 32'd1);
    checks++;
    if (clk_out[0] !== 1'b0) begin
      errors++; $display("FAIL basic_latency: clk_out0=%b expected 0", clk_out[0]);
    end
    for (int k = 0; k < 16; k++) begin
      step();
      checks++;
      if (clk_out[0] !== ((k % 4) < 2) || tick[0] !== ((k % 4) == 3) || clk_out !== m_clk || tick !== m_tick) begin
        errors++; $display("FAIL basic_pattern k=%0d: clk_out=%b tick=%b expected %b %b", k, clk_out, tick, m_clk, m_tick);
      end
    end
  endtask

  task automatic test_frac();
    int nt = 0;
    clean();
    cfg_write(3'd0, 2'd1, 32'd4); cfg_write(3'd1, 2'd1, 32'h8000); cfg_write(3'd2, 2'd1, 32'd2);
    cfg_write(3'd3, 2'd0, 32'h2);
    for (int k = 0; k < 90; k++) begin
      step();
      nt += int'(tick[1]);
      checks++;
      if (clk_out !== m_clk || tick !== m_tick) begin
        errors++; $display("FAIL frac_cycle k=%0d: clk_out=%b tick=%b expected %b %b", k, clk_out, tick, m_clk, m_tick);
      end
    end
    checks++;
    if (nt != 20) begin
      errors++; $display("FAIL frac_tick_count: got %0d expected 20", nt);
    end
  endtask

  task automatic test_retune();
    clean();
    cfg_write(3'd0, 2'd0, 32'd8); cfg_write(3'd2, 2'd0, 32'd4);
    cfg_write(3'd3, 2'd0, 32'h1);
    for (int s = 1; s <= 20; s++) begin
      if (s == 4) cfg_write(3'd0, 2'd0, 32'd4);
      else step();
      checks++;
      if (tick[0] !== (s == 8 || s == 12 || s == 16 || s == 20) ||
          clk_out[0] !== (s <= 4 || s >= 9) || clk_out !== m_clk) begin
        errors++; $display("FAIL retune s=%0d: clk_out=%b tick=%b expected %b %b", s, clk_out, tick, m_clk, m_tick);
      end
    end
  endtask

  task automatic test_multi();
    clean();
    cfg_write(3'd0, 2'd0, 32'd4);  cfg_write(3'd2, 2'd0, 32'd2);
    cfg_write(3'd0, 2'd1, 32'd6);  cfg_write(3'd2, 2'd1, 32'd3);
    cfg_write(3'd0, 2'd2, 32'd10); cfg_write(3'd2, 2'd2, 32'd5);
    cfg_write(3'd0, 2'd3, 32'd3);  cfg_write(3'd2, 2'd3, 32'd1);
    cfg_write(3'd3, 2'd0, 32'hF);
    step();
    checks++;
    if (clk_out !== 4'hF) begin
      errors++; $display("FAIL multi_aligned: clk_out=%b expected 1111", clk_out);
    end
    cfg_write(3'd0, 2'd2, 32'd1);
    for (int k = 0; k < 40; k++) begin
      step();
      checks++;
      if (clk_out !== m_clk || tick !== m_tick || (k >= 20 && (clk_out[2] | tick[2]) !== 1'b0)) begin
        errors++; $display("FAIL multi_cycle k=%0d: clk_out=%b tick=%b expected %b %b", k, clk_out, tick, m_clk, m_tick);
      end
    end
  endtask

  task automatic test_soft_reset();
    clean();
    cfg_write(3'd0, 2'd0, 32'd4); cfg_write(3'd2, 2'd0, 32'd3); cfg_write(3'd3, 2'd0, 32'h1);
    step(); step();
    cfg_write(3'd4, 2'd0, 32'd1);
    checks++;
    if ({ready, clk_out, tick} !== 9'd0) begin
      errors++; $display("FAIL soft_reset_out: ready=%b clk_out=%b tick=%b expected all 0", ready, clk_out, tick);
    end
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (ready !== 1'b1 || clk_out !== 4'h0 || tick !== 4'h0) begin
        errors++; $display("FAIL soft_reset_after k=%0d: ready=%b clk_out=%b tick=%b expected 1 0000 0000", k, ready, clk_out, tick);
      end
    end
  endtask

  task automatic test_async_reset();
    clean();
    cfg_write(3'd0, 2'd0, 32'd4); cfg_write(3'd2, 2'd0, 32'd2); cfg_write(3'd3, 2'd0, 32'h1);
    step(); step();
    #2 arst_n = 1'b0;
    #1;
    model_clear();
    checks++;
    if ({ready, clk_out, tick} !== 9'd0) begin
      errors++; $display("FAIL async_reset: ready=%b clk_out=%b tick=%b expected all 0", ready, clk_out, tick);
    end
    @(negedge clk); arst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (ready !== 1'b1 || clk_out !== 4'h0 || tick !== 4'h0) begin
        errors++; $display("FAIL async_release k=%0d: ready=%b clk_out=%b expected 1 0000", k, ready, clk_out);
      end
    end
  endtask

  task automatic test_phase();
    logic [11:0] h0, h1;
    clean();
    cfg_write(3'd0, 2'd0, 32'd8); cfg_write(3'd2, 2'd0, 32'd4);
    cfg_write(3'd0, 2'd1, 32'd8); cfg_write(3'd2, 2'd1, 32'd4);
    cfg_write(3'd5, 2'd1, 32'd2);
    cfg_write(3'd3, 2'd0, 32'h3);
    for (int k = 0; k < 12; k++) begin
      step();
      h0[k] = clk_out[0]; h1[k] = clk_out[1];
      checks++;
      if (clk_out !== m_clk || tick !== m_tick) begin
        errors++; $display("FAIL phase_cycle k=%0d: clk_out=%b tick=%b expected %b %b", k, clk_out, tick, m_clk, m_tick);
      end
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
`ifdef IOB_NCO_MULTI_PHASE_EN
      if (h1[k] !== h0[k+2]) begin
        errors++; $display("FAIL phase_lead k=%0d: ch1=%b expected ch0+2=%b", k, h1[k], h0[k+2]);
      end
`else
      if (h1[k] !== h0[k]) begin
        errors++; $display("FAIL phase_ignored k=%0d: ch1=%b expected ch0=%b", k, h1[k], h0[k]);
      end
`endif
    end
  endtask

  task automatic test_random();
    clean();
    for (int k = 0; k < 800; k++) begin
      cke   = ($urandom_range(0, 9) != 0);
      valid = $urandom_range(0, 1) == 1;
      sel   = 3'($urandom_range(0, 7));
      ch    = 2'($urandom_range(0, 3));
      case (sel)
        3'd0:    wdata = $urandom_range(0, 12);
        3'd2:    wdata = $urandom_range(0, 14);
        3'd4:    wdata = ($urandom_range(0, 29) == 0) ? 32'd1 : 32'd0;
        3'd5:    wdata = $urandom_range(0, 10);
        default: wdata = $urandom;
      endcase
      step();
      checks++;
      if (clk_out !== m_clk || tick !== m_tick || ready !== m_ready) begin
        errors++; $display("FAIL random k=%0d: clk_out=%b tick=%b ready=%b expected %b %b %b", k, clk_out, tick, ready, m_clk, m_tick, m_ready);
      end
    end
    cke = 1'b1; valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_frac();
    test_retune();
    test_multi();
    test_soft_reset();
    test_async_reset();
    test_phase();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/iob_nco_multi.md
Name: iob_nco_multi

Overview:
Multi-channel numerically controlled oscillator; parametrised successor of the single-channel NCO.
- N_CH independent channels, each with its own fractional period (integer + fractional part) and programmable high time (duty).
- Period, duty and phase are written to shadow registers and take effect only at a period boundary, giving glitch-free retuning.
- A shared enable mask starts several channels on the same cycle.
- Sits behind the peripheral CSR block; drives clock/strobe outputs to timers, PWM and audio blocks.

Parameters:
N_CH, 4, number of channels, 2..16.
INT_W, 16, integer-period and duty width (cycles).
FRAC_W, 16, fractional-period width.
DATA_W, 32, config write-data width; must be >= max(INT_W, FRAC_W, N_CH).
CH_W, $clog2(N_CH), derived localparam; not overridable.

Ports:
- clk_i  in  1  system clock.
- cke_i  in  1  clock enable; when low, all state holds.
- arst_n_i  in  1  asynchronous active-low reset.
- cfg_valid_i  in  1  config write strobe.
- cfg_sel_i  in  3  target register (encoding below).
- cfg_ch_i  in  CH_W  channel index for per-channel registers.
- cfg_wdata_i  in  DATA_W  write data, LSB-aligned.
- cfg_ready_o  out  1  write accepted.
- clk_out_o  out  N_CH  per-channel oscillator outputs, registered.
- tick_o  out  N_CH  one-cycle pulse on the last cycle of each period, registered.

Behaviour:
Clock/reset (already decided): one clock, clk_i. Reset arst_n_i is asynchronous and active-low.
- During reset all registers clear to 0.
- Reset values: cfg_ready_o=0, clk_out_o=0, tick_o=0.
- cfg_ready_o rises one cycle after reset release and stays high, except 1 cycle low after a soft reset.

Config writes: a write occurs when cfg_valid_i && cfg_ready_o on a clk_i edge with cke_i=1. cfg_sel_i encoding:
- 0: shadow period_int[ch].
- 1: shadow period_frac[ch].
- 2: shadow duty[ch].
- 3: enable mask, wdata[N_CH-1:0]; cfg_ch_i ignored.
- 4: soft reset when wdata[0]=1.
- 5: phase[ch], optional feature only.
- 6, 7: ignored.
- Writing cfg_ch_i >= N_CH is ignored.

Per-channel state: active period_int / period_frac / duty, cnt[INT_W], acc[FRAC_W], en.
- Current period length L = act_int + carry, where carry = carry-out of (acc + act_frac).
- Each enabled cycle: if cnt == L-1, then tick, cnt<=0, acc<=acc+act_frac (mod 2^FRAC_W), and active registers reload from shadow. Otherwise cnt<=cnt+1.
- Output function: clk_out = en && act_int>=2 && cnt<act_duty.
  - duty 0 gives constant low.
  - duty >= L gives constant high.
- clk_out_o and tick_o register this function: 1 cycle latency from cnt.
- act_int < 2 (including 0, 1): channel holds cnt, outputs low, no ticks.

Enable rising (mask bit 0->1) at write edge T:
- cnt<=0, acc<=0, active<=shadow, all at the same edge.
- First clk_out_o high in cycle T+2 if duty>0.
- Channels enabled by the same write are phase-aligned.

Enable falling at edge T:
- cnt and acc hold; clk_out_o=0 and tick_o=0 from cycle T+2.
- Disable wins over a simultaneous tick.

Shadow write on the same edge as a period end: the reload takes the old shadow value; the new value applies at the next boundary.

Soft reset: clears all state, shadows and the enable mask, as asynchronous reset does; cfg_ready_o is low for the following cycle.

cke_i=0: everything, including pending writes, holds; no write is accepted.

Optional Feature:
Macro IOB_NCO_MULTI_PHASE_EN.
- Defined: adds per-channel shadow phase[INT_W] (sel 5). On enable rising, cnt<=min(phase, act_int-1) instead of 0, giving fixed phase offsets between synchronously started channels.
- Undefined: sel 5 is ignored and cnt always starts at 0.

Test Plan:
1. ch0 int=4, frac=0, duty=2, enable mask=1 -> clk_out_o[0] pattern 1100 repeating; tick_o[0] every 4 cycles; first high 2 cycles after the write.
2. ch1 int=4, frac=0x8000, duty=2 -> period lengths alternate 4,5; exactly 2 ticks per 9 cycles over 90 cycles (20 ticks).
3. ch0 running int=8; write int=4 at cnt=3 -> current period completes 8 cycles, the next is 4 cycles; no runt pulse.
4. Periods 4/6/10/3, enable mask=0xF in one write -> all four first rising edges in the same cycle; int=1 on one channel -> that channel stays low, no ticks.
5. Assert arst_n_i mid-period, and separately issue soft reset -> all outputs 0 immediately (async) or 1 cycle later (soft); enable mask cleared; cfg_ready_o low for 1 cycle after soft reset.
6. With IOB_NCO_MULTI_PHASE_EN: ch0/ch1 int=8, duty=4, phase 0/2, enabled together -> ch1 leads ch0 by 2 cycles; without the macro, sel 5 has no effect.
